// File: rtl/noc_arb_pkg.sv
//------------------------------------------------------------------------------
// noc_arb_pkg : shared arbitration types and round-robin pick helper
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package noc_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int RR_MAX_REQ   = 16;
  localparam int RR_IDX_WIDTH = 4;

  typedef struct packed {
    logic                    found;
    logic [RR_IDX_WIDTH-1:0] idx;
  } rr_pick_t;

  // First requester at or after ptr, wrapping at num_req (num_req <= RR_MAX_REQ).
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0]   req,
                                       input logic [RR_IDX_WIDTH-1:0] ptr,
                                       input int                      num_req);
    rr_pick_t                res;
    int                      cand;
    logic [RR_IDX_WIDTH-1:0] cidx;
    res = '0;
    for (int k = 0; k < RR_MAX_REQ; k++) begin
      if (k < num_req && !res.found) begin
        cand = (int'(ptr) + k) % num_req;
        cidx = RR_IDX_WIDTH'(cand);
        if (req[cidx]) begin
          res.found = 1'b1;
          res.idx   = cidx;
        end
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_skid_buffer.sv
//------------------------------------------------------------------------------
// axis_skid_buffer : 2-entry ready/valid buffer, ready/valid decoded from state
// Revision         : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  // Ready depends only on occupancy, so downstream ready never reaches upstream.
  assign s_ready = (count != 2'd2);
  assign m_valid = (count != 2'd0);
  assign m_data  = mem[rd_ptr];
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

endmodule

`default_nettype wire

// File: rtl/axis_packet_arbiter.sv
//------------------------------------------------------------------------------
// axis_packet_arbiter : packet-granular round-robin mux of NUM_SRC AXIS sources
// Revision            : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axis_packet_arbiter
  import noc_arb_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int TDATA_WIDTH = 512,
  parameter int TDEST_WIDTH = 3,
  parameter int SRC_WIDTH   = $clog2(NUM_SRC)
) (
  input  logic                           clk_usr,
  input  logic                           rst_usr_sync,
  input  logic [NUM_SRC-1:0]             s_axis_tvalid,
  output logic [NUM_SRC-1:0]             s_axis_tready,
  input  logic [NUM_SRC*TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]             s_axis_tlast,
  input  logic [NUM_SRC*TDEST_WIDTH-1:0] s_axis_tdest,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [TDATA_WIDTH-1:0]         m_axis_tdata,
  output logic                           m_axis_tlast,
  output logic [TDEST_WIDTH-1:0]         m_axis_tdest,
  output logic [SRC_WIDTH-1:0]           m_axis_tid
);

  localparam int BEAT_WIDTH = TDATA_WIDTH + 1 + TDEST_WIDTH + SRC_WIDTH;

  arb_state_e              state;
  logic [SRC_WIDTH-1:0]    rr_ptr;
  logic [SRC_WIDTH-1:0]    lock_id;
  logic [SRC_WIDTH-1:0]    sel;
  logic [SRC_WIDTH-1:0]    sel_next;
  logic [RR_MAX_REQ-1:0]   req_ext;
  rr_pick_t                pick;
  logic                    have_sel;
  logic                    slot_ok;
  logic                    accept;
  logic [TDATA_WIDTH-1:0]  sel_data;
  logic                    sel_last;
  logic [TDEST_WIDTH-1:0]  sel_dest;
  logic [BEAT_WIDTH-1:0]   in_beat;
  logic [BEAT_WIDTH-1:0]   out_beat;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_SRC-1:0]   = s_axis_tvalid;
    pick                   = rr_pick(req_ext, RR_IDX_WIDTH'(rr_ptr), NUM_SRC);
    if (state == ARB_LOCKED) begin
      sel      = lock_id;
      have_sel = 1'b1;
    end else begin
      sel      = SRC_WIDTH'(pick.idx);
      have_sel = pick.found;
    end
  end

  // Grant is one-hot by construction; suppressed while reset is held.
  always_comb begin
    s_axis_tready = '0;
    if (have_sel && slot_ok && !rst_usr_sync) s_axis_tready[sel] = 1'b1;
  end

  assign accept   = |(s_axis_tready & s_axis_tvalid);
  assign sel_data = s_axis_tdata[sel*TDATA_WIDTH +: TDATA_WIDTH];
  assign sel_dest = s_axis_tdest[sel*TDEST_WIDTH +: TDEST_WIDTH];
  assign sel_last = s_axis_tlast[sel];
  assign sel_next = (sel == SRC_WIDTH'(NUM_SRC - 1)) ? '0 : sel + 1'b1;
  assign in_beat  = {sel_data, sel_last, sel_dest, sel};

  always_ff @(posedge clk_usr) begin
    if (rst_usr_sync) begin
      state   <= ARB_IDLE;
      rr_ptr  <= '0;
      lock_id <= '0;
    end else if (accept) begin
      if (sel_last) begin
        state  <= ARB_IDLE;
        rr_ptr <= sel_next;
      end else begin
        state   <= ARB_LOCKED;
        lock_id <= sel;
      end
    end
  end

  axis_skid_buffer #(
    .WIDTH (BEAT_WIDTH)
  ) u_skid (
    .clk     (clk_usr),
    .rst     (rst_usr_sync),
    .s_valid (accept),
    .s_ready (slot_ok),
    .s_data  (in_beat),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready),
    .m_data  (out_beat)
  );

  assign {m_axis_tdata, m_axis_tlast, m_axis_tdest, m_axis_tid} = out_beat;

endmodule

`default_nettype wire

// File: tb/tb_axis_packet_arbiter.sv
//------------------------------------------------------------------------------
// tb_axis_packet_arbiter : directed scenarios plus randomized packet traffic
// Revision               : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_axis_packet_arbiter;

  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int DSTW = 3;
  localparam int SW   = 2;

  logic              clk_usr = 1'b0;
  logic              rst_usr_sync;
  logic [N-1:0]      s_axis_tvalid;
  logic [N-1:0]      s_axis_tready;
  logic [N*DW-1:0]   s_axis_tdata;
  logic [N-1:0]      s_axis_tlast;
  logic [N*DSTW-1:0] s_axis_tdest;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic              m_axis_tlast;
  logic [DSTW-1:0]   m_axis_tdest;
  logic [SW-1:0]     m_axis_tid;

  always #5 clk_usr = ~clk_usr;

  axis_packet_arbiter #(
    .NUM_SRC     (N),
    .TDATA_WIDTH (DW),
    .TDEST_WIDTH (DSTW),
    .SRC_WIDTH   (SW)
  ) dut (
    .clk_usr       (clk_usr),
    .rst_usr_sync  (rst_usr_sync),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tdest  (s_axis_tdest),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tdest  (m_axis_tdest),
    .m_axis_tid    (m_axis_tid)
  );

  typedef struct {
    logic [DW-1:0]   data;
    logic            last;
    logic [DSTW-1:0] dest;
  } beat_t;

  typedef struct {
    logic [DW-1:0]   data;
    logic            last;
    logic [DSTW-1:0] dest;
    int              tid;
  } obeat_t;

  beat_t         srcq [N][$];
  obeat_t        got [$];
  logic [N-1:0]  present;
  int            tests;
  int            fails;

  logic [N-1:0]    snap_tready;
  logic            snap_mvalid;
  logic [DW-1:0]   snap_mdata;
  logic            snap_mlast;
  logic [DSTW-1:0] snap_mdest;
  logic [SW-1:0]   snap_mtid;

  function automatic beat_t mk_beat(input logic [DW-1:0] d, input logic l, input logic [DSTW-1:0] t);
    beat_t b;
    b.data = d;
    b.last = l;
    b.dest = t;
    return b;
  endfunction

  // Output-side monitor: every completed m_axis handshake is recorded.
  always @(negedge clk_usr) begin
    if (rst_usr_sync === 1'b0 && m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1)
      got.push_back('{m_axis_tdata, m_axis_tlast, m_axis_tdest, int'(m_axis_tid)});
  end

  always @(negedge clk_usr) begin
    if (rst_usr_sync === 1'b0) begin
      tests++;
      assert ($onehot0(s_axis_tready)) else begin
        fails++;
        $display("FAIL tready_onehot0 at %0t: tready=%b required one-hot-or-zero", $time, s_axis_tready);
      end
    end
  end

  // One clock of source driving: heads of the queues are presented, accepted heads popped.
  task automatic cycle();
    logic [N-1:0] v;
    for (int s = 0; s < N; s++) begin
      v[s] = present[s] && (srcq[s].size() > 0);
      if (v[s]) begin
        s_axis_tdata[s*DW +: DW]     = srcq[s][0].data;
        s_axis_tlast[s]              = srcq[s][0].last;
        s_axis_tdest[s*DSTW +: DSTW] = srcq[s][0].dest;
      end else begin
        s_axis_tdata[s*DW +: DW]     = '0;
        s_axis_tlast[s]              = 1'b0;
        s_axis_tdest[s*DSTW +: DSTW] = '0;
      end
    end
    s_axis_tvalid = v;
    @(negedge clk_usr);
    snap_tready = s_axis_tready;
    snap_mvalid = m_axis_tvalid;
    snap_mdata  = m_axis_tdata;
    snap_mlast  = m_axis_tlast;
    snap_mdest  = m_axis_tdest;
    snap_mtid   = m_axis_tid;
    @(posedge clk_usr);
    #1;
    for (int s = 0; s < N; s++)
      if (snap_tready[s] && v[s]) void'(srcq[s].pop_front());
  endtask

  task automatic clear_sources();
    for (int s = 0; s < N; s++) srcq[s].delete();
    present = '1;
  endtask

  task automatic do_reset();
    rst_usr_sync  = 1'b1;
    m_axis_tready = 1'b1;
    clear_sources();
    cycle();
    cycle();
    rst_usr_sync = 1'b0;
    got.delete();
  endtask

  task automatic test_reset();
    rst_usr_sync  = 1'b1;
    m_axis_tready = 1'b1;
    clear_sources();
    for (int s = 0; s < N; s++) srcq[s].push_back(mk_beat(32'(s + 1), 1'b1, 3'd0));
    for (int c = 0; c < 3; c++) begin
      cycle();
      tests += 2;
      if (snap_tready !== 4'b0000) begin
        fails++;
        $display("FAIL reset_tready cycle %0d: got %b required 0000", c, snap_tready);
      end
      if (snap_mvalid !== 1'b0) begin
        fails++;
        $display("FAIL reset_mvalid cycle %0d: got %b required 0", c, snap_mvalid);
      end
    end
    clear_sources();
    rst_usr_sync = 1'b0;
  endtask

  task automatic test_single_beats();
    do_reset();
    srcq[0].push_back(mk_beat(32'hA, 1'b1, 3'd1));
    srcq[2].push_back(mk_beat(32'hC, 1'b1, 3'd2));
    cycle();
    tests += 2;
    if (snap_tready !== 4'b0001) begin fails++; $display("FAIL single_grant0: got %b required 0001", snap_tready); end
    if (snap_mvalid !== 1'b0) begin fails++; $display("FAIL single_latency: mvalid %b required 0", snap_mvalid); end
    cycle();
    tests += 2;
    if (snap_tready !== 4'b0100) begin fails++; $display("FAIL single_grant2: got %b required 0100", snap_tready); end
    if (snap_mvalid !== 1'b1 || snap_mtid !== 2'd0 || snap_mdata !== 32'hA || snap_mdest !== 3'd1) begin
      fails++;
      $display("FAIL single_out0: valid %b tid %0d data %h dest %0d required 1 0 a 1", snap_mvalid, snap_mtid, snap_mdata, snap_mdest);
    end
    cycle();
    tests += 2;
    if (snap_tready !== 4'b0000) begin fails++; $display("FAIL single_idle: got %b required 0000", snap_tready); end
    if (snap_mvalid !== 1'b1 || snap_mtid !== 2'd2 || snap_mdata !== 32'hC || snap_mlast !== 1'b1) begin
      fails++;
      $display("FAIL single_out2: valid %b tid %0d data %h last %b required 1 2 c 1", snap_mvalid, snap_mtid, snap_mdata, snap_mlast);
    end
    cycle();
    tests++;
    if (snap_mvalid !== 1'b0) begin fails++; $display("FAIL single_empty: mvalid %b required 0", snap_mvalid); end
  endtask

  task automatic test_lock();
    logic [DW-1:0] exp_data [4];
    int            exp_tid [4];
    exp_data = '{32'h10, 32'h11, 32'h12, 32'h30};
    exp_tid  = '{1, 1, 1, 3};
    do_reset();
    srcq[1].push_back(mk_beat(32'h10, 1'b0, 3'd4));
    srcq[1].push_back(mk_beat(32'h11, 1'b0, 3'd4));
    srcq[1].push_back(mk_beat(32'h12, 1'b1, 3'd4));
    cycle();
    srcq[3].push_back(mk_beat(32'h30, 1'b1, 3'd5));
    for (int c = 0; c < 3; c++) begin
      if (c > 0) cycle();
      tests++;
      if (snap_tready !== 4'b0010) begin fails++; $display("FAIL lock_hold beat %0d: got %b required 0010", c, snap_tready); end
    end
    cycle();
    tests++;
    if (snap_tready !== 4'b1000) begin fails++; $display("FAIL lock_release: got %b required 1000", snap_tready); end
    repeat (3) cycle();
    tests++;
    if (got.size() != 4) begin
      fails++;
      $display("FAIL lock_count: got %0d beats required 4", got.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (got[k].data !== exp_data[k] || got[k].tid != exp_tid[k]) begin
          fails++;
          $display("FAIL lock_order[%0d]: got tid %0d data %h required tid %0d data %h", k, got[k].tid, got[k].data, exp_tid[k], exp_data[k]);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_tid [10];
    int budget;
    exp_tid = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    do_reset();
    for (int s = 0; s < N; s++)
      for (int p = 0; p < 3; p++)
        for (int b = 0; b < 2; b++)
          srcq[s].push_back(mk_beat(32'(s*256 + p*2 + b), (b == 1), 3'(s)));
    budget = 0;
    while (got.size() < 10 && budget < 60) begin
      cycle();
      budget++;
    end
    tests++;
    if (got.size() < 10) begin
      fails++;
      $display("FAIL rr_timeout: got %0d beats required 10", got.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        tests++;
        if (got[k].tid != exp_tid[k]) begin
          fails++;
          $display("FAIL rr_tid[%0d]: got %0d required %0d", k, got[k].tid, exp_tid[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int budget;
    do_reset();
    for (int b = 0; b < 4; b++) srcq[0].push_back(mk_beat(32'h40 + 32'(b), (b == 3), 3'd6));
    cycle();
    m_axis_tready = 1'b0;
    cycle();
    tests++;
    if (snap_tready !== 4'b0001) begin fails++; $display("FAIL bp_second_slot: got %b required 0001", snap_tready); end
    for (int c = 0; c < 4; c++) begin
      cycle();
      tests += 2;
      if (snap_tready !== 4'b0000) begin fails++; $display("FAIL bp_tready stall %0d: got %b required 0000", c, snap_tready); end
      if (snap_mvalid !== 1'b1 || snap_mdata !== 32'h40 || snap_mtid !== 2'd0 || snap_mlast !== 1'b0) begin
        fails++;
        $display("FAIL bp_stable stall %0d: valid %b data %h tid %0d last %b required 1 40 0 0", c, snap_mvalid, snap_mdata, snap_mtid, snap_mlast);
      end
    end
    tests++;
    if (srcq[0].size() != 2) begin fails++; $display("FAIL bp_buffered: accepted %0d beats required 2", 4 - srcq[0].size()); end
    m_axis_tready = 1'b1;
    budget = 0;
    while (got.size() < 4 && budget < 12) begin
      cycle();
      budget++;
    end
    repeat (2) cycle();
    tests++;
    if (got.size() != 4) begin
      fails++;
      $display("FAIL bp_drain_count: got %0d beats required 4", got.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (got[k].data !== 32'h40 + 32'(k) || got[k].last !== (k == 3)) begin
          fails++;
          $display("FAIL bp_drain[%0d]: got data %h last %b required %h %b", k, got[k].data, got[k].last, 32'h40 + 32'(k), (k == 3));
        end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    m_axis_tready = 1'b0;
    for (int b = 0; b < 3; b++) srcq[2].push_back(mk_beat(32'h50 + 32'(b), (b == 2), 3'd3));
    cycle();
    tests++;
    if (snap_tready !== 4'b0100) begin fails++; $display("FAIL rstmid_first: got %b required 0100", snap_tready); end
    rst_usr_sync = 1'b1;
    cycle();
    tests++;
    if (snap_tready !== 4'b0000) begin fails++; $display("FAIL rstmid_in_reset: got %b required 0000", snap_tready); end
    rst_usr_sync = 1'b0;
    clear_sources();
    got.delete();
    m_axis_tready = 1'b1;
    srcq[1].push_back(mk_beat(32'h61, 1'b1, 3'd0));
    srcq[2].push_back(mk_beat(32'h62, 1'b1, 3'd0));
    srcq[3].push_back(mk_beat(32'h63, 1'b1, 3'd0));
    cycle();
    tests += 2;
    if (snap_mvalid !== 1'b0) begin fails++; $display("FAIL rstmid_flushed: mvalid %b required 0", snap_mvalid); end
    if (snap_tready !== 4'b0010) begin fails++; $display("FAIL rstmid_regrant: got %b required 0010", snap_tready); end
    cycle();
    tests++;
    if (snap_mvalid !== 1'b1 || snap_mtid !== 2'd1 || snap_mdata !== 32'h61) begin
      fails++;
      $display("FAIL rstmid_out: valid %b tid %0d data %h required 1 1 61", snap_mvalid, snap_mtid, snap_mdata);
    end
  endtask

  // Randomized traffic against a packet-level reference: owner/pointer + 2-deep queue.
  task automatic test_random();
    int           owner;
    int           ptr;
    int           g;
    int           len;
    int           idx;
    obeat_t       mbuf [$];
    logic [N-1:0] v;
    logic [N-1:0] stuck;
    logic [N-1:0] exp_rdy;
    logic         slot;
    beat_t        hb;
    do_reset();
    owner = -1;
    ptr   = 0;
    stuck = '0;
    hb    = mk_beat('0, 1'b0, '0);
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int s = 0; s < N; s++) begin
        if (srcq[s].size() == 0 && $urandom_range(0, 2) == 0) begin
          len = int'($urandom_range(1, 4));
          for (int b = 0; b < len; b++)
            srcq[s].push_back(mk_beat($urandom, (b == len - 1), 3'($urandom_range(0, 7))));
        end
        present[s] = stuck[s] || ($urandom_range(0, 3) != 0);
        v[s]       = present[s] && (srcq[s].size() > 0);
      end
      m_axis_tready = ($urandom_range(0, 3) != 0);
      slot = (mbuf.size() < 2);
      g = -1;
      if (owner >= 0) g = owner;
      else
        for (int k = 0; k < N; k++) begin
          idx = (ptr + k) % N;
          if (g < 0 && v[idx]) g = idx;
        end
      exp_rdy = (slot && g >= 0) ? (4'b0001 << g) : 4'b0000;
      if (g >= 0 && srcq[g].size() > 0) hb = srcq[g][0];
      cycle();
      tests += 2;
      if (snap_tready !== exp_rdy) begin
        fails++;
        $display("FAIL rand_tready cycle %0d: got %b required %b", cyc, snap_tready, exp_rdy);
      end
      if (snap_mvalid !== (mbuf.size() > 0)) begin
        fails++;
        $display("FAIL rand_mvalid cycle %0d: got %b required %b", cyc, snap_mvalid, (mbuf.size() > 0));
      end else if (mbuf.size() > 0) begin
        tests++;
        if (snap_mdata !== mbuf[0].data || snap_mlast !== mbuf[0].last ||
            snap_mdest !== mbuf[0].dest || int'(snap_mtid) != mbuf[0].tid) begin
          fails++;
          $display("FAIL rand_beat cycle %0d: got %h/%b/%0d/%0d required %h/%b/%0d/%0d", cyc,
                   snap_mdata, snap_mlast, snap_mdest, snap_mtid,
                   mbuf[0].data, mbuf[0].last, mbuf[0].dest, mbuf[0].tid);
        end
      end
      if (mbuf.size() > 0 && m_axis_tready) void'(mbuf.pop_front());
      if (g >= 0 && slot && v[g]) begin
        mbuf.push_back('{hb.data, hb.last, hb.dest, g});
        if (hb.last) begin
          owner = -1;
          ptr   = (g + 1) % N;
        end else begin
          owner = g;
        end
      end
      stuck = v & ~snap_tready;
    end
    present = '1;
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    rst_usr_sync  = 1'b1;
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tlast  = '0;
    s_axis_tdest  = '0;
    m_axis_tready = 1'b1;
    present       = '1;
    @(posedge clk_usr);
    #1;
    test_reset();
    test_single_beats();
    test_lock();
    test_round_robin();
    test_backpressure();
    test_reset_mid_packet();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
